// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: valid/ready handshake, optional 2-entry skid buffer,
// flush-to-bubble, and a saturating counter of cycles where downstream was starved.
module pipe_stage_reg #(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 104,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 0,
    parameter int CNT_W      = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data,
    output logic [CNT_W-1:0]  Bubble_Count
);

    logic              main_vld_q, main_vld_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_vld_q, skid_vld_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_rdy_q, in_rdy_d;
    logic [CNT_W-1:0]  bcnt_q, bcnt_d;
    logic              xfer_in;
    logic              xfer_out;

    // With the skid buffer, In_Ready comes from a register so the upstream path never sees Out_Ready.
    assign In_Ready  = ~Rst & ((SKID != 0) ? in_rdy_q : (~main_vld_q | Out_Ready));
    assign xfer_in   = In_Valid & In_Ready;
    assign xfer_out  = main_vld_q & Out_Ready;

    assign Out_Valid    = main_vld_q;
    assign Out_Ctrl     = main_ctrl_q;
    assign Out_Data     = main_data_q;
    assign Bubble_Count = bcnt_q;

    always_comb begin
        main_vld_d  = main_vld_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_vld_d  = skid_vld_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (Flush) begin
            main_vld_d  = 1'b0;
            main_ctrl_d = '0;
            skid_vld_d  = 1'b0;
            skid_ctrl_d = '0;
            if (CLEAR_DATA != 0) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else if (xfer_out || !main_vld_q) begin
            if (skid_vld_q) begin
                main_vld_d  = 1'b1;
                main_ctrl_d = skid_ctrl_q;
                main_data_d = skid_data_q;
                skid_vld_d  = 1'b0;
                skid_ctrl_d = '0;
            end else if (xfer_in) begin
                main_vld_d  = 1'b1;
                main_ctrl_d = In_Ctrl;
                main_data_d = In_Data;
            end else begin
                // Going empty: control drops to a no-op, data keeps its last value.
                main_vld_d  = 1'b0;
                main_ctrl_d = '0;
            end
        end else if (xfer_in && (SKID != 0)) begin
            skid_vld_d  = 1'b1;
            skid_ctrl_d = In_Ctrl;
            skid_data_d = In_Data;
        end

        in_rdy_d = ~skid_vld_d;

        bcnt_d = bcnt_q;
        if (Out_Ready && !main_vld_q && !(&bcnt_q)) begin
            bcnt_d = bcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            main_vld_q  <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            in_rdy_q    <= 1'b1;
            bcnt_q      <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_rdy_q    <= in_rdy_d;
            bcnt_q      <= bcnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three parameterisations share one stimulus stream and are
// checked every cycle against a FIFO-level model plus hand-computed literal expectations.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic [7:0]   in_ctrl;
    logic [103:0] in_data;
    logic         out_ready;

    logic         in_rdy   [3];
    logic         out_vld  [3];
    logic [7:0]   out_ctrl [3];
    logic [103:0] out_data [3];
    logic [15:0]  bcnt     [3];
    logic [3:0]   bc0;
    logic [3:0]   bc1;
    logic [15:0]  bc2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // 0: SKID=1 CLEAR_DATA=0 CNT_W=4, 1: SKID=0 CLEAR_DATA=1 CNT_W=4, 2: SKID=1 CLEAR_DATA=1 CNT_W=16
    pipe_stage_reg #(.CTRL_W(8), .DATA_W(104), .SKID(1), .CLEAR_DATA(0), .CNT_W(4)) u_a (
        .Clk(clk), .Rst(rst), .Flush(flush), .In_Valid(in_valid), .In_Ready(in_rdy[0]),
        .In_Ctrl(in_ctrl), .In_Data(in_data), .Out_Valid(out_vld[0]), .Out_Ready(out_ready),
        .Out_Ctrl(out_ctrl[0]), .Out_Data(out_data[0]), .Bubble_Count(bc0));
    pipe_stage_reg #(.CTRL_W(8), .DATA_W(104), .SKID(0), .CLEAR_DATA(1), .CNT_W(4)) u_b (
        .Clk(clk), .Rst(rst), .Flush(flush), .In_Valid(in_valid), .In_Ready(in_rdy[1]),
        .In_Ctrl(in_ctrl), .In_Data(in_data), .Out_Valid(out_vld[1]), .Out_Ready(out_ready),
        .Out_Ctrl(out_ctrl[1]), .Out_Data(out_data[1]), .Bubble_Count(bc1));
    pipe_stage_reg #(.CTRL_W(8), .DATA_W(104), .SKID(1), .CLEAR_DATA(1), .CNT_W(16)) u_c (
        .Clk(clk), .Rst(rst), .Flush(flush), .In_Valid(in_valid), .In_Ready(in_rdy[2]),
        .In_Ctrl(in_ctrl), .In_Data(in_data), .Out_Valid(out_vld[2]), .Out_Ready(out_ready),
        .Out_Ctrl(out_ctrl[2]), .Out_Data(out_data[2]), .Bubble_Count(bc2));

    assign bcnt[0] = {12'd0, bc0};
    assign bcnt[1] = {12'd0, bc1};
    assign bcnt[2] = bc2;

    function automatic bit p_skid(input int i);
        return (i != 1);
    endfunction
    function automatic bit p_clear(input int i);
        return (i != 0);
    endfunction
    function automatic int p_max(input int i);
        return (i == 2) ? 65535 : 15;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
    endtask

    // Model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid); m_hold is the data left on the bus when empty.
    int           m_n    [3];
    logic [111:0] m_e    [3][2];
    logic [103:0] m_hold [3];
    int           m_bc   [3];

    always @(posedge clk or posedge rst) begin : model
        int           n;
        logic [111:0] e0, e1;
        bit           vld, rdy;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_n[i]    <= 0;
                m_e[i][0] <= '0;
                m_e[i][1] <= '0;
                m_hold[i] <= '0;
                m_bc[i]   <= 0;
            end else begin
                n   = m_n[i];
                e0  = m_e[i][0];
                e1  = m_e[i][1];
                vld = (n > 0);
                rdy = p_skid(i) ? (n < 2) : (n == 0 || out_ready);
                if (!vld && out_ready && m_bc[i] < p_max(i)) m_bc[i] <= m_bc[i] + 1;
                if (flush) begin
                    m_n[i] <= 0;
                    if (p_clear(i)) m_hold[i] <= '0;
                end else begin
                    if (vld && out_ready) begin
                        e0 = e1;
                        n--;
                    end
                    if (in_valid && rdy) begin
                        if (n == 0) e0 = {in_ctrl, in_data};
                        else        e1 = {in_ctrl, in_data};
                        n++;
                    end
                    m_n[i]    <= n;
                    m_e[i][0] <= e0;
                    m_e[i][1] <= e1;
                    if (n > 0) m_hold[i] <= e0[103:0];
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        bit           e_vld, e_rdy;
        logic [7:0]   e_ctrl;
        logic [103:0] e_data;
        for (int i = 0; i < 3; i++) begin
            e_vld  = (m_n[i] > 0);
            e_rdy  = !rst && (p_skid(i) ? (m_n[i] < 2) : (m_n[i] == 0 || out_ready));
            e_ctrl = e_vld ? m_e[i][0][111:104] : 8'h00;
            e_data = e_vld ? m_e[i][0][103:0] : m_hold[i];
            chk($sformatf("cmp%0d_in_ready", i), in_rdy[i], e_rdy);
            chk($sformatf("cmp%0d_out_valid", i), out_vld[i], e_vld);
            chk($sformatf("cmp%0d_out_ctrl", i), out_ctrl[i], e_ctrl);
            chk($sformatf("cmp%0d_out_data", i), out_data[i], e_data);
            chk($sformatf("cmp%0d_bubble", i), bcnt[i], m_bc[i]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one entry until stage 0 takes it (bounded).
    task automatic offer(input logic [7:0] c, input logic [103:0] d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            done = in_rdy[0];
            tick();
        end
        in_valid = 1'b0;
        chk("offer_accepted", done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_ctrl = 8'hEE; in_data = 104'hEE; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready_a", in_rdy[0], 1'b0);
        chk("rst_in_ready_b", in_rdy[1], 1'b0);
        chk("rst_out_valid_a", out_vld[0], 1'b0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;

        // Streaming 0x01..0x08
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_ctrl  = 8'h80 | 8'(k);
            in_data  = 104'(k);
            @(negedge clk);
            chk("stream_in_ready_a", in_rdy[0], 1'b1);
            if (k >= 2) chk("stream_order_a", out_data[0], k - 1);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_last_data_a", out_data[0], 104'h08);
        chk("stream_last_ctrl_a", out_ctrl[0], 8'h88);
        chk("stream_bubble_a", bcnt[0], 1);
        chk("stream_bubble_b", bcnt[1], 1);
        chk("stream_bubble_c", bcnt[2], 1);
        tick();
        @(negedge clk);
        chk("drain_valid_a", out_vld[0], 1'b0);
        chk("drain_ctrl_a", out_ctrl[0], 8'h00);
        chk("drain_hold_data_a", out_data[0], 104'h08);
        tick();

        // Back-pressure
        out_ready = 1'b0;
        offer(8'hA1, 104'hA1);
        offer(8'hA2, 104'hA2);
        in_valid = 1'b1; in_ctrl = 8'hA3; in_data = 104'hA3;
        repeat (3) begin
            @(negedge clk);
            chk("bp_full_in_ready_a", in_rdy[0], 1'b0);
            chk("bp_stall_data_a", out_data[0], 104'hA1);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_out1_a", out_data[0], 104'hA1);
        chk("bp_still_full_a", in_rdy[0], 1'b0);
        tick();
        @(negedge clk);
        chk("bp_out2_a", out_data[0], 104'hA2);
        chk("bp_ready_again_a", in_rdy[0], 1'b1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_out3_a", out_data[0], 104'hA3);
        tick();

        // Flush while FULL with a simultaneous input
        out_ready = 1'b0;
        offer(8'hB1, 104'hB1);
        offer(8'hB2, 104'hB2);
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 8'h55; in_data = 104'h55;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid_a", out_vld[0], 1'b0);
        chk("flush_ctrl_a", out_ctrl[0], 8'h00);
        chk("flush_in_ready_a", in_rdy[0], 1'b1);
        chk("flush_keep_data_a", out_data[0], 104'hB1);
        chk("flush_clear_data_b", out_data[1], 104'h0);
        chk("flush_clear_data_c", out_data[2], 104'h0);
        out_ready = 1'b1;
        tick();
        tick();

        // Combinational In_Ready without skid buffer
        out_ready = 1'b0;
        offer(8'hC1, 104'hC1);
        in_valid = 1'b1; in_ctrl = 8'hC2; in_data = 104'hC2; out_ready = 1'b1;
        #1 chk("comb_ready_hi_b", in_rdy[1], 1'b1);
        out_ready = 1'b0;
        #1 chk("comb_ready_lo_b", in_rdy[1], 1'b0);
        out_ready = 1'b1;
        #1 chk("comb_ready_hi2_b", in_rdy[1], 1'b1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("comb_swap_data_b", out_data[1], 104'hC2);
        chk("comb_swap_valid_b", out_vld[1], 1'b1);
        chk("swap_data_a", out_data[0], 104'hC2);
        tick();

        // Counter saturation
        repeat (20) tick();
        @(negedge clk);
        chk("sat_bubble_a", bcnt[0], 15);
        chk("sat_bubble_b", bcnt[1], 15);
        tick();
        offer(8'hD1, 104'hD1);
        offer(8'hD2, 104'hD2);
        tick();
        @(negedge clk);
        chk("sat_hold_a", bcnt[0], 15);
        chk("sat_hold_b", bcnt[1], 15);
        tick();

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        offer(8'hE1, 104'hE1);
        offer(8'hE2, 104'hE2);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid_a", out_vld[0], 1'b0);
        chk("arst_ctrl_a", out_ctrl[0], 8'h00);
        chk("arst_data_a", out_data[0], 104'h0);
        chk("arst_in_ready_a", in_rdy[0], 1'b0);
        chk("arst_bubble_a", bcnt[0], 0);
        chk("arst_valid_c", out_vld[2], 1'b0);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register. It is the successor to the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle of configurable width, with a valid/ready handshake, an optional 2-entry skid buffer for back-pressure, and a flush (bubble-insert) input.
- Includes a saturating starvation counter for pipeline performance monitoring.
- Sits between any two CPU stages; the stage-specific fields are packed into the In_Ctrl and In_Data vectors by the instantiating stage.

Parameters:
- CTRL_W, 8: width of the control bundle. Control bits are forced to 0 for a bubble/no-op.
- DATA_W, 104: width of the data bundle (ALU result, store data, PC values, register number, ...).
- SKID, 1: 1 gives a 2-entry skid buffer with registered In_Ready; 0 gives a single register with combinational In_Ready.
- CLEAR_DATA, 0: 1 zeroes the data bundle on flush and on reset; 0 zeroes it on reset only.
- CNT_W, 16: width of the Bubble_Count counter.

Ports:
- Clk  in  1  clock; all state changes on its rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Flush  in  1  synchronous flush: discards all held entries and inserts a bubble.
- In_Valid  in  1  upstream holds a valid entry.
- In_Ready  out  1  stage accepts an entry this cycle.
- In_Ctrl  in  CTRL_W  upstream control bundle.
- In_Data  in  DATA_W  upstream data bundle.
- Out_Valid  out  1  Out_Ctrl/Out_Data carry a valid entry.
- Out_Ready  in  1  downstream accepts this cycle.
- Out_Ctrl  out  CTRL_W  control to the next stage; all 0 whenever Out_Valid=0.
- Out_Data  out  DATA_W  data to the next stage.
- Bubble_Count  out  CNT_W  count of starved cycles, saturating.

Behaviour:
- Handshake rules:
  - Transfer in occurs when In_Valid & In_Ready.
  - Transfer out occurs when Out_Valid & Out_Ready.
  - An entry is never duplicated, dropped (except on Flush) or reordered.
- Reset (Rst=1, asynchronous, takes effect immediately and holds while asserted):
  - Out_Valid=0, Out_Ctrl=0, Out_Data=0, Bubble_Count=0, all internal entries invalid.
  - In_Ready=0 while Rst=1; In_Ready=1 from the first cycle after release.
  - Reset mid-transfer loses the in-flight entries; this is required.
- Out_Ctrl masking: Out_Ctrl is a registered value. It is 0 in every cycle where Out_Valid=0, so consumers that ignore Out_Valid see a no-op.
- Out_Data when Out_Valid=0: keeps the last value, unless reset or (flush with CLEAR_DATA=1) zeroed it.
- SKID=0:
  - In_Ready = ~Out_Valid | Out_Ready (combinational).
  - On transfer in, the output register loads In_Ctrl/In_Data and Out_Valid=1 next cycle. Latency is 1 cycle.
  - On transfer out with no transfer in, Out_Valid=0 and Out_Ctrl=0 next cycle.
- SKID=1, with state EMPTY (0 entries), ONE (main register valid) and FULL (main + skid valid):
  - In_Ready = (state != FULL), registered; it does not depend combinationally on Out_Ready.
  - EMPTY + in → ONE.
  - ONE + in + out → ONE (main loads the new entry).
  - ONE + in + no out → FULL (skid captures the new entry).
  - ONE + out + no in → EMPTY.
  - FULL + out → ONE (main loads from skid). No input is possible in FULL.
  - Latency is 1 cycle when not stalled. Sustained throughput is 1 entry/cycle.
- Flush:
  - Takes priority over every other event in the same cycle.
  - Next cycle: all entries invalid (state EMPTY), Out_Valid=0, Out_Ctrl=0, Out_Data zeroed only if CLEAR_DATA=1.
  - An input offered in the flush cycle is discarded, even if In_Ready=1.
  - An output presented in the flush cycle with Out_Ready=1 counts as transferred; the downstream stage owns it.
  - Flush with Rst=1 has no effect beyond reset.
- Bubble_Count:
  - Increments by 1 on each cycle with Out_Ready=1 & Out_Valid=0 & Rst=0.
  - Saturates at 2^CNT_W-1 and never wraps.
- Stall: Out_Ready=0 holds all outputs stable. Out_Valid, once asserted, is not deasserted until transfer out, flush or reset.

Test Plan:
- Reset/flow, SKID=1: assert Rst with In_Valid=1; release; stream entries 0x01..0x08 with Out_Ready=1. Required: In_Ready=0 during reset; outputs 0x01..0x08 appear in order, each 1 cycle after acceptance; Bubble_Count=1 (the first cycle only).
- Back-pressure, SKID=1: stream 0xA1, 0xA2, 0xA3 with Out_Ready=0 from cycle 1. Required: 0xA1 and 0xA2 accepted, then In_Ready=0 with 0xA3 held upstream. Raise Out_Ready: 0xA1, 0xA2, 0xA3 delivered in order with no duplication.
- Flush while FULL and simultaneous input: Flush=1 with In_Valid=1 and In_Data=0x55. Required: next cycle Out_Valid=0, Out_Ctrl=0, In_Ready=1; 0x55 never appears at the output. With CLEAR_DATA=1, Out_Data=0; with CLEAR_DATA=0, Out_Data keeps its previous value.
- SKID=0 combinational path: Out_Valid=1, toggle Out_Ready 1/0/1. Required: In_Ready follows Out_Ready in the same cycle; a new entry is accepted in the same cycle the old one leaves.
- Counter saturation, CNT_W=4: In_Valid=0 and Out_Ready=1 for 20 cycles. Required: Bubble_Count=15 and holding; it stays 15 after valid traffic resumes.
- Async reset mid-stream: pulse Rst between clock edges while the stage is FULL. Required: Out_Valid=0 and Out_Ctrl=0 immediately, before the next edge.
